// File: rtl/psum_server.sv
// Partial-sum server: returns one accumulation word per request (RAM or zero on
// the first pass), writes results back in request order, and serves host reads between passes.
module psum_server #(
    parameter int DataWidth = 32,
    parameter int AddrWidth = 10
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 cfg_start,
    input  logic                 cfg_first,
    input  logic [AddrWidth:0]   cfg_len,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    input  logic                 accum_request,
    output logic [DataWidth-1:0] accum_data,
    output logic                 accum_valid,
    input  logic [DataWidth-1:0] result_in,
    input  logic                 result_valid,
    input  logic                 host_rd_en,
    input  logic [AddrWidth-1:0] host_rd_addr,
    output logic [DataWidth-1:0] host_rd_data
);

    localparam logic [AddrWidth:0] Depth  = {1'b1, {AddrWidth{1'b0}}};
    localparam logic [AddrWidth:0] CntOne = {{AddrWidth{1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, RUN, WAIT_WB} state_t;
    state_t state, state_nxt;

    logic [DataWidth-1:0] mem [2**AddrWidth];
    logic [AddrWidth:0]   req_cnt, wb_cnt, len;
    logic [AddrWidth-1:0] rd_ptr, wr_ptr;
    logic                 first;
    logic                 req_acc, wb_acc, start_ok, start_bad, err_set, done_nxt;
    logic                 ram_rd_en;
    logic [AddrWidth-1:0] ram_rd_addr;
    logic [DataWidth-1:0] ram_q, acc_hold, host_hold;
    logic                 acc_zero, host_pend;

    // Every pass starts at address 0, so the pointers are the counters' low bits.
    assign rd_ptr = req_cnt[AddrWidth-1:0];
    assign wr_ptr = wb_cnt[AddrWidth-1:0];
    assign busy   = (state != IDLE);

    always_comb begin
        state_nxt = state;
        req_acc   = 1'b0;
        start_ok  = 1'b0;
        start_bad = 1'b0;
        done_nxt  = 1'b0;
        wb_acc    = (state != IDLE) && result_valid && (wb_cnt != req_cnt);
        case (state)
            IDLE: begin
                if (cfg_start) begin
                    if (cfg_len == '0 || cfg_len > Depth) begin
                        start_bad = 1'b1;
                    end else begin
                        start_ok  = 1'b1;
                        state_nxt = RUN;
                    end
                end
            end
            RUN: begin
                req_acc = accum_request;
                if (accum_request && (req_cnt + CntOne == len)) state_nxt = WAIT_WB;
            end
            WAIT_WB: begin
                if (wb_acc && (wb_cnt + CntOne == len)) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
        err_set = start_bad | (accum_request && state != RUN) | (result_valid && !wb_acc);
    end

    // Single read port shared: request path in RUN, host path in IDLE.
    assign ram_rd_en   = (req_acc && !first) || (state == IDLE && host_rd_en);
    assign ram_rd_addr = (state == RUN) ? rd_ptr : host_rd_addr;

    always_ff @(posedge Clk) begin
        if (wb_acc) mem[wr_ptr] <= result_in;
        if (ram_rd_en) ram_q <= mem[ram_rd_addr];
    end

    assign accum_data   = accum_valid ? (acc_zero ? '0 : ram_q) : acc_hold;
    assign host_rd_data = host_pend ? ram_q : host_hold;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state       <= IDLE;
            req_cnt     <= '0;
            wb_cnt      <= '0;
            len         <= '0;
            first       <= 1'b0;
            err         <= 1'b0;
            done        <= 1'b0;
            accum_valid <= 1'b0;
            acc_zero    <= 1'b0;
            acc_hold    <= '0;
            host_pend   <= 1'b0;
            host_hold   <= '0;
        end else begin
            state       <= state_nxt;
            done        <= done_nxt;
            accum_valid <= req_acc;
            acc_zero    <= first;
            host_pend   <= (state == IDLE) && host_rd_en;
            if (accum_valid) acc_hold <= accum_data;
            if (host_pend) host_hold <= host_rd_data;
            if (start_ok) begin
                len     <= cfg_len;
                first   <= cfg_first;
                req_cnt <= '0;
                wb_cnt  <= '0;
            end else begin
                if (req_acc) req_cnt <= req_cnt + CntOne;
                if (wb_acc) wb_cnt <= wb_cnt + CntOne;
            end
            // A protocol error in the same cycle as a good start still sticks.
            if (err_set) err <= 1'b1;
            else if (start_ok) err <= 1'b0;
        end
    end

endmodule
